// File: rtl/posit_pkg.sv
// rtl/posit_pkg.sv - shared widths, posit constants and stage-register flags
package posit_pkg;

  localparam int MAX_N = 64;

  function automatic int posit_bs(input int n);
    return $clog2(n);
  endfunction

  function automatic int posit_sw(input int n, input int e);
    return e + posit_bs(n) + 2;
  endfunction

  function automatic logic [MAX_N-1:0] posit_maxpos(input int n);
    return (MAX_N'(1) << (n - 1)) - MAX_N'(1);
  endfunction

  function automatic logic [MAX_N-1:0] posit_minpos(input int n);
    return MAX_N'(n > 0);
  endfunction

  function automatic logic [MAX_N-1:0] posit_nar(input int n);
    return MAX_N'(1) << (n - 1);
  endfunction

  typedef struct packed {
    logic sign;
    logic zero;
    logic nar;
    logic guard;
    logic rnd;
    logic sticky;
  } stage_flags_t;

endpackage

// File: rtl/posit_round.sv
// rtl/posit_round.sv - RNE rounding, saturation to maxpos/minpos, sign and special values
module posit_round
  import posit_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-2:0]  i_mag,
  input  stage_flags_t  i_flags,
  output logic [N-1:0]  o_word
);

  localparam logic [N-1:0] L_MAXPOS = N'(posit_maxpos(N));
  localparam logic [N-1:0] L_MINPOS = N'(posit_minpos(N));
  localparam logic [N-1:0] L_NAR    = N'(posit_nar(N));

  logic         w_up;
  logic [N-1:0] w_sum;
  logic [N-2:0] w_rmag;
  logic [N-1:0] w_uword;

  assign w_up  = i_flags.guard & (i_mag[0] | i_flags.rnd | i_flags.sticky);
  assign w_sum = {1'b0, i_mag} + {{(N-1){1'b0}}, w_up};

  // Rounding may neither overflow into NaR nor collapse a nonzero value to zero.
  always_comb begin
    w_rmag = w_sum[N-2:0];
    if (w_sum[N-1]) begin
      w_rmag = L_MAXPOS[N-2:0];
    end else if (w_sum[N-2:0] == '0) begin
      w_rmag = L_MINPOS[N-2:0];
    end
  end

  assign w_uword = {1'b0, w_rmag};

  always_comb begin
    if (i_flags.nar) begin
      o_word = L_NAR;
    end else if (i_flags.zero) begin
      o_word = '0;
    end else if (i_flags.sign) begin
      o_word = -w_uword;
    end else begin
      o_word = w_uword;
    end
  end

endmodule

// File: rtl/posit_pack.sv
// rtl/posit_pack.sv - two-stage posit encoder from sign/scale/fraction with valid/ready flow control
module posit_pack
  import posit_pkg::*;
#(
  parameter int N  = 32,
  parameter int es = 2,
  parameter int FW = N
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_sign,
  input  logic [posit_sw(N,es)-1:0] in_scale,
  input  logic [FW-1:0]             in_frac,
  input  logic                      in_sticky,
  input  logic                      in_zero,
  input  logic                      in_nar,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [N-1:0]              out_posit
);

  localparam int SW  = posit_sw(N, es);
  localparam int KW  = SW - es;
  localparam int SHW = es + FW + N;
  localparam logic signed [SW-1:0] L_SC_MAX = SW'((N - 2) * (2 ** es));
  localparam logic signed [SW-1:0] L_SC_MIN = SW'(-((N - 2) * (2 ** es)));
  localparam logic [N-1:0] L_MAXPOS = N'(posit_maxpos(N));
  localparam logic [N-1:0] L_MINPOS = N'(posit_minpos(N));

  logic                  w_k_neg;
  logic [KW-1:0]         w_k;
  logic [KW-1:0]         w_amt;
  logic [SHW-1:0]        w_x;
  logic signed [SHW-1:0] w_sh;
  logic                  w_sat_hi;
  logic                  w_sat_lo;
  logic [N-2:0]          w_mag;
  stage_flags_t          w_flags;
  logic [N-1:0]          w_round;
  logic                  w_s2_load;

  logic                  r_s1_valid;
  logic [N-2:0]          r_s1_mag;
  stage_flags_t          r_s1_flags;
  logic                  r_s2_valid;
  logic [N-1:0]          r_s2_word;

  // The top scale bits are floor(scale / 2^es). Seeding "10" (k>=0) or "01" (k<0)
  // above the exponent/fraction and arithmetic-shifting by k or ~k builds the regime.
  assign w_k     = in_scale[SW-1:es];
  assign w_k_neg = w_k[KW-1];
  assign w_amt   = w_k_neg ? ~w_k : w_k;
  assign w_x     = {~w_k_neg, w_k_neg, in_scale[es-1:0], in_frac, {(N-2){1'b0}}};
  assign w_sh    = $signed(w_x) >>> w_amt;

  assign w_sat_hi = $signed(in_scale) > L_SC_MAX;
  assign w_sat_lo = $signed(in_scale) < L_SC_MIN;

  always_comb begin
    w_mag          = w_sh[SHW-1 -: N-1];
    w_flags.sign   = in_sign;
    w_flags.zero   = in_zero;
    w_flags.nar    = in_nar;
    w_flags.guard  = w_sh[SHW-N];
    w_flags.rnd    = w_sh[SHW-N-1];
    w_flags.sticky = (|w_sh[SHW-N-2:0]) | in_sticky;
    if (w_sat_hi || w_sat_lo) begin
      w_mag          = w_sat_hi ? L_MAXPOS[N-2:0] : L_MINPOS[N-2:0];
      w_flags.guard  = 1'b0;
      w_flags.rnd    = 1'b0;
      w_flags.sticky = 1'b0;
    end
  end

  posit_round #(.N(N)) u_round (
    .i_mag   (r_s1_mag),
    .i_flags (r_s1_flags),
    .o_word  (w_round)
  );

  assign w_s2_load = ~r_s2_valid | out_ready;
  assign in_ready  = ~r_s1_valid | w_s2_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_mag   <= '0;
      r_s1_flags <= '0;
      r_s2_valid <= 1'b0;
      r_s2_word  <= '0;
    end else begin
      if (in_ready) begin
        r_s1_valid <= in_valid;
      end
      if (in_ready && in_valid) begin
        r_s1_mag   <= w_mag;
        r_s1_flags <= w_flags;
      end
      if (w_s2_load) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s2_word <= w_round;
        end
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign out_posit = r_s2_word;

endmodule

// File: tb/tb_posit_pack.sv
// tb/tb_posit_pack.sv - scoreboard bench for posit_pack at N=32, es=2, FW=32
module tb_posit_pack;

  localparam int N  = 32;
  localparam int ES = 2;
  localparam int FW = 32;
  localparam int SW = 9;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic          in_sign;
  logic [SW-1:0] in_scale;
  logic [FW-1:0] in_frac;
  logic          in_sticky;
  logic          in_zero;
  logic          in_nar;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_posit;

  always #5 clk = ~clk;

  posit_pack #(.N(N), .es(ES), .FW(FW)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_scale  (in_scale),
    .in_frac   (in_frac),
    .in_sticky (in_sticky),
    .in_zero   (in_zero),
    .in_nar    (in_nar),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_posit (out_posit)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] cur_exp;
  logic [31:0] held;
  bit          accepted;
  bit          stalled_prev;
  bit          toggle_mode;
  int          tcyc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Independent reference: builds the posit bit string one bit at a time.
  function automatic logic [31:0] model(input bit s, input int sc, input logic [31:0] fr,
                                        input bit st, input bit z, input bit nar);
    bit          bits[$];
    logic [31:0] mag;
    bit          g;
    bit          rest;
    int          k;
    int          e;
    if (nar) return 32'h8000_0000;
    if (z) return 32'h0;
    if (sc > 120) mag = 32'h7FFF_FFFF;
    else if (sc < -120) mag = 32'h1;
    else begin
      k = sc >>> 2;
      e = sc & 3;
      if (k >= 0) begin
        for (int i = 0; i <= k; i++) bits.push_back(1'b1);
        bits.push_back(1'b0);
      end else begin
        for (int i = 0; i < -k; i++) bits.push_back(1'b0);
        bits.push_back(1'b1);
      end
      bits.push_back(e[1]);
      bits.push_back(e[0]);
      for (int i = 31; i >= 0; i--) bits.push_back(fr[i]);
      mag = 0;
      for (int i = 0; i < 31; i++) mag = {mag[30:0], bits[i]};
      g = bits[31];
      rest = st;
      for (int i = 32; i < bits.size(); i++) rest |= bits[i];
      if (g && (rest || mag[0])) mag++;
      if (mag[31]) mag = 32'h7FFF_FFFF;
      if (mag == 0) mag = 32'h1;
    end
    return s ? -mag : mag;
  endfunction

  // One clock cycle: inputs are already set at the falling edge; evaluate what the next rising edge transfers.
  task automatic step();
    if (toggle_mode) begin
      out_ready = (tcyc % 3 == 0);
      tcyc++;
    end
    #1;
    accepted = 1'b0;
    if (in_valid && in_ready) begin
      exp_q.push_back(cur_exp);
      accepted = 1'b1;
    end
    if (stalled_prev) begin
      check("stall_valid", 32'(out_valid), 32'h1);
      check("stall_hold", out_posit, held);
    end
    stalled_prev = 1'b0;
    if (out_valid) begin
      if (out_ready) begin
        if (exp_q.size() == 0) check("spurious_valid", 32'(out_valid), 32'h0);
        else check("out_posit", out_posit, exp_q.pop_front());
      end else begin
        stalled_prev = 1'b1;
        held = out_posit;
      end
    end
    @(negedge clk);
  endtask

  task automatic send(input bit s, input int sc, input logic [31:0] fr, input bit st,
                      input bit z, input bit nar, input logic [31:0] exp);
    in_valid  = 1'b1;
    in_sign   = s;
    in_scale  = SW'(sc);
    in_frac   = fr;
    in_sticky = st;
    in_zero   = z;
    in_nar    = nar;
    cur_exp   = exp;
    accepted  = 1'b0;
    for (int i = 0; i < 50 && !accepted; i++) step();
    if (!accepted) check("accept_timeout", 32'(in_ready), 32'h1);
    in_valid = 1'b0;
  endtask

  task automatic send_m(input bit s, input int sc, input logic [31:0] fr, input bit st);
    send(s, sc, fr, st, 1'b0, 1'b0, model(s, sc, fr, st, 1'b0, 1'b0));
  endtask

  task automatic drain();
    in_valid = 1'b0;
    for (int i = 0; i < 200 && exp_q.size() > 0; i++) step();
    check("drain_empty", 32'(exp_q.size()), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_sign = 1'b0; in_scale = '0;
    in_frac = '0; in_sticky = 1'b0; in_zero = 1'b0; in_nar = 1'b0;
    toggle_mode = 1'b0; tcyc = 0; stalled_prev = 1'b0; cur_exp = '0; held = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h1);
    check("rst_out_posit", out_posit, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    send(0, 0, 32'h0, 0, 0, 0, 32'h4000_0000);
    send(1, 0, 32'h0, 0, 0, 0, 32'hC000_0000);
    send(0, 4, 32'h0, 0, 0, 0, 32'h6000_0000);
    send(0, -1, 32'h0, 0, 0, 0, 32'h3800_0000);
    send(0, 0, 32'h10, 0, 0, 0, 32'h4000_0000);
    send(0, 0, 32'h10, 1, 0, 0, 32'h4000_0001);
    send(0, 200, 32'h0, 0, 0, 0, 32'h7FFF_FFFF);
    send(0, -200, 32'h0, 0, 0, 0, 32'h0000_0001);
    send(1, -200, 32'h0, 0, 0, 0, 32'hFFFF_FFFF);
    send(1, 37, $urandom(), 1, 1, 1, 32'h8000_0000);
    send(1, -5, $urandom(), 1, 1, 0, 32'h0000_0000);
    drain();

    send_m(0, 120, 32'hFFFF_FFFF, 1);
    send_m(0, 121, 32'h0, 0);
    send_m(0, -120, 32'hFFFF_FFFF, 1);
    send_m(1, -121, 32'h0, 0);
    send_m(0, -1, 32'hFFFF_FFFF, 0);
    send_m(1, 7, 32'h0000_0030, 0);
    for (int i = 0; i < 20; i++)
      send_m(1'($urandom()), int'($urandom_range(0, 260)) - 130, $urandom(), 1'($urandom()));
    drain();

    toggle_mode = 1'b1;
    tcyc = 0;
    for (int i = 0; i < 10; i++)
      send_m(1'($urandom()), int'($urandom_range(0, 100)) - 50, $urandom(), 1'($urandom()));
    drain();
    toggle_mode = 1'b0;
    out_ready = 1'b1;

    out_ready = 1'b0;
    send_m(0, 3, 32'h1234_5678, 0);
    send_m(1, -9, 32'h8765_4321, 0);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'h0);
    check("midrst_in_ready", 32'(in_ready), 32'h1);
    check("midrst_out_posit", out_posit, 32'h0);
    exp_q.delete();
    stalled_prev = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    in_valid = 1'b1; in_sign = 1'b0; in_scale = SW'(4); in_frac = '0;
    in_sticky = 1'b0; in_zero = 1'b0; in_nar = 1'b0;
    #1;
    check("lat_in_ready", 32'(in_ready), 32'h1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("lat_cycle1", 32'(out_valid), 32'h0);
    @(negedge clk);
    #1;
    check("lat_cycle2", 32'(out_valid), 32'h1);
    check("lat_posit", out_posit, 32'h6000_0000);
    @(negedge clk);
    step();
    check("post_lat_idle", 32'(out_valid), 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/posit_pack.md
POSIT_PACK -- requirements
Module: posit_pack

Interface
REQ-001 Parameter N, default 32: posit word width.
REQ-002 Parameter es, default 2: exponent field width.
REQ-003 Parameter FW, default N: width of the input fraction, hidden bit excluded, MSB weight 2^-1.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 in_valid  input  1  input operand valid.
REQ-007 in_ready  output  1  block accepts the operand this cycle.
REQ-008 in_sign  input  1  sign of the value.
REQ-009 in_scale  input  es+$clog2(N)+2  signed two's-complement scale: value = 2^scale * 1.frac.
REQ-010 in_frac  input  FW  fraction bits below the hidden 1.
REQ-011 in_sticky  input  1  OR of all discarded bits below in_frac.
REQ-012 in_zero  input  1  value is exactly zero.
REQ-013 in_nar  input  1  value is NaR.
REQ-014 out_valid  output  1  out_posit valid.
REQ-015 out_ready  input  1  downstream accepts out_posit.
REQ-016 out_posit  output  N  encoded posit.

Function
REQ-017 Transfer occurs on a valid&ready cycle at either port; nothing else moves data.
REQ-018 Two register stages: S1 computes regime/exponent/fraction bit string and guard/round/sticky; S2 holds the rounded, sign-applied word; latency is 2 cycles with no stall.
REQ-019 Each stage loads when it is empty or its downstream consumes it in the same cycle; in_ready = ~S1_full | S1 advancing; with out_ready held high, throughput is 1 per cycle.
REQ-020 While out_valid=1 and out_ready=0, out_posit and out_valid hold stable.
REQ-021 Regime k = floor(scale / 2^es) (arithmetic shift); exponent field = scale[es-1:0].
REQ-022 k>=0 encodes as k+1 ones then a zero; k<0 encodes as -k zeros then a one; the terminator is omitted when the regime fills N-1 bits.
REQ-023 Scale > (N-2)*2^es saturates to maxpos (0 followed by N-1 ones); scale < -(N-2)*2^es saturates to minpos (N-1 zeros followed by a one).
REQ-024 Rounding is round-to-nearest-even on the N-1 magnitude bits; sticky = OR of all truncated fraction/exponent bits and in_sticky.
REQ-025 Rounding never yields zero or NaR: a carry past maxpos gives maxpos, and a nonzero magnitude rounding to 0 gives minpos.
REQ-026 in_sign=1 outputs the two's complement of the rounded unsigned word.
REQ-027 in_nar=1 outputs 1 followed by N-1 zeros; otherwise in_zero=1 outputs all zeros; NaR has priority; other inputs are ignored in both cases.

Reset
REQ-028 rst_n low clears both stage-valid flags at once: out_valid=0, in_ready=1, out_posit=0.
REQ-029 Reset mid-operation discards in-flight operands; the first accepted operand after release appears 2 cycles later.

Structure
REQ-030 Package posit_pkg holds the Bs=$clog2(N) and scale-width functions, maxpos/minpos/NaR constants and the stage-register struct typedef.
REQ-031 One combinational sub-module, posit_round, implements REQ-024 to REQ-026; posit_pack instantiates it between S1 and S2.

Verification (N=32, es=2, FW=32)
REQ-032 sign=0, scale=0, frac=0 -> 0x40000000; sign=1 -> 0xC0000000; scale=4 -> 0x60000000; scale=-1 -> 0x38000000.
REQ-033 scale=0, frac=0x00000010, sticky=0 (exact tie) -> 0x40000000; the same with sticky=1 -> 0x40000001.
REQ-034 scale=200 -> 0x7FFFFFFF; scale=-200 -> 0x00000001; scale=-200, sign=1 -> 0xFFFFFFFF.
REQ-035 in_nar=1 with in_zero=1 -> 0x80000000; in_zero=1 alone -> 0x00000000.
REQ-036 10 back-to-back operands with out_ready toggling 1,0,0,1,... -> all 10 outputs in order, none lost or duplicated, outputs stable while stalled.
REQ-037 rst_n pulsed low with 2 operands in flight -> out_valid=0 the same cycle; after release, one operand -> out_valid after exactly 2 cycles.
